// File: rtl/aq_biu_rd_chnl_fifo_if.sv
// rtl/aq_biu_rd_chnl_fifo_if.sv - core-side and pad-side read-channel signal bundle
interface aq_biu_rd_chnl_fifo_if #(
  parameter int PADDR = 40,
  parameter int DATAW = 128,
  parameter int IDW   = 4,
  parameter int LENW  = 2
);
  // core AR
  logic             arvalid;
  logic             arready;
  logic [PADDR-1:0] araddr;
  logic [IDW-1:0]   arid;
  logic [LENW-1:0]  arlen;
  logic [2:0]       arsize;
  logic [1:0]       arburst;
  logic [3:0]       arcache;
  logic [2:0]       arprot;
  logic             arlock;
  // pad AR
  logic             biu_pad_arvalid;
  logic             pad_biu_arready;
  logic [PADDR-1:0] biu_pad_araddr;
  logic [7:0]       biu_pad_arid;
  logic [7:0]       biu_pad_arlen;
  logic [2:0]       biu_pad_arsize;
  logic [1:0]       biu_pad_arburst;
  logic [3:0]       biu_pad_arcache;
  logic [2:0]       biu_pad_arprot;
  logic             biu_pad_arlock;
  // pad R
  logic             pad_biu_rvalid;
  logic             biu_pad_rready;
  logic [DATAW-1:0] pad_biu_rdata;
  logic [7:0]       pad_biu_rid;
  logic             pad_biu_rlast;
  logic [1:0]       pad_biu_rresp;
  // core R
  logic             rvalid;
  logic             rready;
  logic [DATAW-1:0] rdata;
  logic [IDW-1:0]   rid;
  logic             rlast;
  logic [1:0]       rresp;

  // buffer side
  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, arcache, arprot, arlock,
    output arready,
    output biu_pad_arvalid, biu_pad_araddr, biu_pad_arid, biu_pad_arlen, biu_pad_arsize,
           biu_pad_arburst, biu_pad_arcache, biu_pad_arprot, biu_pad_arlock,
    input  pad_biu_arready,
    input  pad_biu_rvalid, pad_biu_rdata, pad_biu_rid, pad_biu_rlast, pad_biu_rresp,
    output biu_pad_rready,
    output rvalid, rdata, rid, rlast, rresp,
    input  rready
  );

  // requester and pad model side
  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, arcache, arprot, arlock,
    input  arready,
    input  biu_pad_arvalid, biu_pad_araddr, biu_pad_arid, biu_pad_arlen, biu_pad_arsize,
           biu_pad_arburst, biu_pad_arcache, biu_pad_arprot, biu_pad_arlock,
    output pad_biu_arready,
    output pad_biu_rvalid, pad_biu_rdata, pad_biu_rid, pad_biu_rlast, pad_biu_rresp,
    input  biu_pad_rready,
    input  rvalid, rdata, rid, rlast, rresp,
    output rready
  );
endinterface

// File: rtl/aq_biu_rd_chnl_fifo.sv
// rtl/aq_biu_rd_chnl_fifo.sv - AXI read-channel AR/R buffer with outstanding-read credit cap
module aq_biu_rd_chnl_fifo #(
  parameter int PADDR   = 40,
  parameter int DATAW   = 128,
  parameter int IDW     = 4,
  parameter int LENW    = 2,
  parameter int ARDEPTH = 2,
  parameter int RDEPTH  = 2,
  parameter int MAXOUT  = 4
) (
  input  logic                         biu_clk,
  input  logic                         cpurst,
  input  logic                         axim_clk_en,
  aq_biu_rd_chnl_fifo_if.slave         bus,
  output logic [$clog2(MAXOUT+1)-1:0]  rd_credit_cnt,
  output logic                         rd_unexp_last,
  output logic                         read_channel_clk_en
);

  localparam int ARPW = (ARDEPTH > 1) ? $clog2(ARDEPTH) : 1;
  localparam int RPW  = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int ARCW = $clog2(ARDEPTH + 1);
  localparam int RCW  = $clog2(RDEPTH + 1);
  localparam int CRW  = $clog2(MAXOUT + 1);

  typedef struct packed {
    logic [PADDR-1:0] addr;
    logic [7:0]       id;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic             lock;
  } ar_ent_t;

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic [IDW-1:0]   id;
    logic             last;
    logic [1:0]       resp;
  } r_ent_t;

  ar_ent_t           ar_mem [ARDEPTH];
  logic [ARPW-1:0]   ar_wptr;
  logic [ARPW-1:0]   ar_rptr;
  logic [ARCW-1:0]   ar_cnt;

  r_ent_t            r_mem [RDEPTH];
  logic [RPW-1:0]    r_wptr;
  logic [RPW-1:0]    r_rptr;
  logic [RCW-1:0]    r_cnt;

  logic [CRW-1:0]    crd;
  logic              unexp_q;

  logic              ar_push;
  logic              ar_pop;
  logic              r_push;
  logic              r_pop;
  logic              crd_inc;
  logic              crd_dec;
  ar_ent_t           ar_in;
  ar_ent_t           ar_head;
  r_ent_t            r_in;
  r_ent_t            r_head;

  // Handshake qualification; reset blocks every transfer on both sides.
  always_comb begin
    bus.arready         = !cpurst && (ar_cnt != ARCW'(ARDEPTH)) && (crd < CRW'(MAXOUT));
    bus.biu_pad_arvalid = (ar_cnt != '0);
    bus.biu_pad_rready  = !cpurst && (r_cnt != RCW'(RDEPTH));
    bus.rvalid          = (r_cnt != '0);
    ar_push = bus.arvalid && bus.arready;
    ar_pop  = !cpurst && bus.biu_pad_arvalid && bus.pad_biu_arready && axim_clk_en;
    r_push  = bus.pad_biu_rvalid && bus.biu_pad_rready && axim_clk_en;
    r_pop   = !cpurst && bus.rvalid && bus.rready;
    crd_inc = ar_push;
    crd_dec = r_push && bus.pad_biu_rlast;
    read_channel_clk_en = ar_push || ar_pop || r_push || r_pop ||
                          (ar_cnt != '0) || (r_cnt != '0);
  end

  // Pack incoming entries; ID and length are widened to the pad's 8-bit fields.
  always_comb begin
    ar_in       = '0;
    ar_in.addr  = bus.araddr;
    ar_in.id    = 8'(bus.arid);
    ar_in.len   = 8'(bus.arlen);
    ar_in.size  = bus.arsize;
    ar_in.burst = bus.arburst;
    ar_in.cache = bus.arcache;
    ar_in.prot  = bus.arprot;
    ar_in.lock  = bus.arlock;
    r_in        = '0;
    r_in.data   = bus.pad_biu_rdata;
    r_in.id     = bus.pad_biu_rid[IDW-1:0];
    r_in.last   = bus.pad_biu_rlast;
    r_in.resp   = bus.pad_biu_rresp;
  end

  // Head entries drive the outputs; cleared storage makes them read 0 after reset.
  always_comb begin
    ar_head = ar_mem[ar_rptr];
    r_head  = r_mem[r_rptr];
    bus.biu_pad_araddr  = ar_head.addr;
    bus.biu_pad_arid    = ar_head.id;
    bus.biu_pad_arlen   = ar_head.len;
    bus.biu_pad_arsize  = ar_head.size;
    bus.biu_pad_arburst = ar_head.burst;
    bus.biu_pad_arcache = ar_head.cache;
    bus.biu_pad_arprot  = ar_head.prot;
    bus.biu_pad_arlock  = ar_head.lock;
    bus.rdata           = r_head.data;
    bus.rid             = r_head.id;
    bus.rlast           = r_head.last;
    bus.rresp           = r_head.resp;
    rd_credit_cnt       = crd;
    rd_unexp_last       = unexp_q;
  end

  // AR FIFO storage, pointers and occupancy.
  always_ff @(posedge biu_clk) begin
    if (cpurst) begin
      for (int i = 0; i < ARDEPTH; i++) ar_mem[i] <= '0;
      ar_wptr <= '0;
      ar_rptr <= '0;
      ar_cnt  <= '0;
    end else begin
      if (ar_push) begin
        ar_mem[ar_wptr] <= ar_in;
        ar_wptr <= (ar_wptr == ARPW'(ARDEPTH - 1)) ? '0 : ar_wptr + 1'b1;
      end
      if (ar_pop) begin
        ar_rptr <= (ar_rptr == ARPW'(ARDEPTH - 1)) ? '0 : ar_rptr + 1'b1;
      end
      if (ar_push && !ar_pop) begin
        ar_cnt <= ar_cnt + 1'b1;
      end else if (!ar_push && ar_pop) begin
        ar_cnt <= ar_cnt - 1'b1;
      end
    end
  end

  // R FIFO storage, pointers and occupancy; a full FIFO never pushes since rready is registered.
  always_ff @(posedge biu_clk) begin
    if (cpurst) begin
      for (int i = 0; i < RDEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (r_push) begin
        r_mem[r_wptr] <= r_in;
        r_wptr <= (r_wptr == RPW'(RDEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (r_pop) begin
        r_rptr <= (r_rptr == RPW'(RDEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      if (r_push && !r_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!r_push && r_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Outstanding-read credits; an rlast with nothing outstanding is flagged and sticks.
  always_ff @(posedge biu_clk) begin
    if (cpurst) begin
      crd     <= '0;
      unexp_q <= 1'b0;
    end else if (crd_inc && !crd_dec) begin
      crd <= crd + 1'b1;
    end else if (!crd_inc && crd_dec) begin
      if (crd == '0) begin
        unexp_q <= 1'b1;
      end else begin
        crd <= crd - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aq_biu_rd_chnl_fifo.sv
// tb/tb_aq_biu_rd_chnl_fifo.sv - directed self-checking bench for aq_biu_rd_chnl_fifo
module tb_aq_biu_rd_chnl_fifo;

  logic       biu_clk;
  logic       cpurst;
  logic       axim_clk_en;
  logic [2:0] rd_credit_cnt;
  logic       rd_unexp_last;
  logic       read_channel_clk_en;

  int n_checks;
  int n_errors;

  aq_biu_rd_chnl_fifo_if #(.PADDR(40), .DATAW(128), .IDW(4), .LENW(2)) bus ();

  aq_biu_rd_chnl_fifo #(
    .PADDR(40), .DATAW(128), .IDW(4), .LENW(2),
    .ARDEPTH(2), .RDEPTH(2), .MAXOUT(4)
  ) dut (
    .biu_clk            (biu_clk),
    .cpurst             (cpurst),
    .axim_clk_en        (axim_clk_en),
    .bus                (bus),
    .rd_credit_cnt      (rd_credit_cnt),
    .rd_unexp_last      (rd_unexp_last),
    .read_channel_clk_en(read_channel_clk_en)
  );

  initial biu_clk = 1'b0;
  always #5 biu_clk = ~biu_clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge biu_clk);
    #1;
  endtask

  task automatic ar_drive(input logic [39:0] a, input logic [3:0] id, input logic [1:0] len);
    bus.araddr = a;
    bus.arid   = id;
    bus.arlen  = len;
  endtask

  task automatic r_drive(input logic [127:0] d, input logic [7:0] id, input logic last,
                         input logic [1:0] resp);
    bus.pad_biu_rdata = d;
    bus.pad_biu_rid   = id;
    bus.pad_biu_rlast = last;
    bus.pad_biu_rresp = resp;
  endtask

  localparam logic [39:0]  ADDR_A = 40'h12_3456_7880;
  localparam logic [39:0]  ADDR_B = 40'h10_0000_0040;
  localparam logic [127:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] D1 = 128'h8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff;
  localparam logic [127:0] D2 = 128'hdead_beef_0000_0000_0000_0000_cafe_f00d;
  localparam logic [127:0] DA = 128'h0000_0000_0000_0000_0000_0000_0000_00a1;
  localparam logic [127:0] DB = 128'h0000_0000_0000_0000_0000_0000_0000_00b2;
  localparam logic [127:0] E0 = 128'h1000;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cpurst = 1'b1;
    axim_clk_en = 1'b1;
    bus.arvalid = 1'b1;
    ar_drive(40'h0, 4'h0, 2'h0);
    bus.arsize = 3'd4;
    bus.arburst = 2'd1;
    bus.arcache = 4'hf;
    bus.arprot = 3'd2;
    bus.arlock = 1'b0;
    bus.pad_biu_arready = 1'b1;
    bus.pad_biu_rvalid = 1'b1;
    r_drive(D0, 8'h01, 1'b1, 2'd0);
    bus.rready = 1'b1;

    // reset held two cycles with activity offered on every input
    tick();
    tick();
    chk("rst_arready", bus.arready, 0);
    chk("rst_rready", bus.biu_pad_rready, 0);
    chk("rst_pad_arvalid", bus.biu_pad_arvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_credit", rd_credit_cnt, 0);
    chk("rst_araddr", bus.biu_pad_araddr, 0);
    chk("rst_rdata", bus.rdata, 0);
    bus.arvalid = 1'b0;
    bus.pad_biu_rvalid = 1'b0;
    bus.rready = 1'b0;
    bus.pad_biu_arready = 1'b0;
    cpurst = 1'b0;
    #1;
    chk("rel_arready", bus.arready, 1);
    chk("rel_rready", bus.biu_pad_rready, 1);

    // AR stall, then pops gated by axim_clk_en
    bus.arvalid = 1'b1;
    ar_drive(ADDR_A, 4'h5, 2'd3);
    tick();
    ar_drive(ADDR_B, 4'ha, 2'd1);
    #1;
    chk("ar1_valid", bus.biu_pad_arvalid, 1);
    chk("ar1_id", bus.biu_pad_arid, 8'h05);
    chk("ar1_len", bus.biu_pad_arlen, 8'h03);
    chk("ar1_addr", bus.biu_pad_araddr, ADDR_A);
    chk("ar1_credit", rd_credit_cnt, 1);
    chk("ar1_size", bus.biu_pad_arsize, 3'd4);
    tick();
    bus.arvalid = 1'b0;
    #1;
    chk("ar2_full_arready", bus.arready, 0);
    chk("ar2_credit", rd_credit_cnt, 2);
    chk("ar2_head", bus.biu_pad_araddr, ADDR_A);
    bus.pad_biu_arready = 1'b1;
    axim_clk_en = 1'b0;
    tick();
    chk("en0_hold_addr", bus.biu_pad_araddr, ADDR_A);
    chk("en0_hold_id", bus.biu_pad_arid, 8'h05);
    axim_clk_en = 1'b1;
    tick();
    axim_clk_en = 1'b0;
    #1;
    chk("pop1_addr", bus.biu_pad_araddr, ADDR_B);
    chk("pop1_id", bus.biu_pad_arid, 8'h0a);
    chk("pop1_len", bus.biu_pad_arlen, 8'h01);
    chk("pop1_arready", bus.arready, 1);
    tick();
    chk("en0_hold_b", bus.biu_pad_araddr, ADDR_B);
    chk("en0_valid_b", bus.biu_pad_arvalid, 1);
    axim_clk_en = 1'b1;
    tick();
    chk("pop2_empty", bus.biu_pad_arvalid, 0);

    // credit cap at MAXOUT
    bus.arvalid = 1'b1;
    ar_drive(40'h00_0000_0100, 4'h1, 2'd0);
    tick();
    tick();
    bus.arvalid = 1'b0;
    #1;
    chk("cap_credit", rd_credit_cnt, 4);
    chk("cap_arready", bus.arready, 0);
    chk("cap_pad_valid", bus.biu_pad_arvalid, 1);
    tick();
    chk("cap_drained_arready", bus.arready, 0);
    chk("cap_drained_valid", bus.biu_pad_arvalid, 0);
    bus.pad_biu_rvalid = 1'b1;
    r_drive(DA, 8'h03, 1'b1, 2'd0);
    tick();
    bus.pad_biu_rvalid = 1'b0;
    #1;
    chk("rlast_credit", rd_credit_cnt, 3);
    chk("rlast_arready", bus.arready, 1);
    chk("rlast_rvalid", bus.rvalid, 1);
    chk("rlast_rdata", bus.rdata, DA);
    chk("rlast_rid", bus.rid, 4'h3);
    chk("rlast_last", bus.rlast, 1);
    bus.arvalid = 1'b1;
    bus.pad_biu_rvalid = 1'b1;
    r_drive(DB, 8'h04, 1'b1, 2'd3);
    tick();
    bus.arvalid = 1'b0;
    bus.pad_biu_rvalid = 1'b0;
    #1;
    chk("inc_dec_credit", rd_credit_cnt, 3);
    chk("rfull_rready", bus.biu_pad_rready, 0);
    bus.rready = 1'b1;
    tick();
    chk("rpop_rdata", bus.rdata, DB);
    chk("rpop_rresp", bus.rresp, 2'd3);
    tick();
    bus.rready = 1'b0;
    bus.pad_biu_arready = 1'b0;
    #1;
    chk("rpop_empty", bus.rvalid, 0);
    chk("rpop_arempty", bus.biu_pad_arvalid, 0);

    // R backpressure: pop while full does not admit the offered beat
    bus.pad_biu_rvalid = 1'b1;
    r_drive(D0, 8'h11, 1'b1, 2'd0);
    tick();
    r_drive(D1, 8'h12, 1'b1, 2'd2);
    tick();
    chk("bp_full_rready", bus.biu_pad_rready, 0);
    chk("bp_credit2", rd_credit_cnt, 1);
    r_drive(D2, 8'h13, 1'b1, 2'd1);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    #1;
    chk("bp_head_d1", bus.rdata, D1);
    chk("bp_d2_not_taken", rd_credit_cnt, 1);
    chk("bp_rready_back", bus.biu_pad_rready, 1);
    tick();
    bus.pad_biu_rvalid = 1'b0;
    #1;
    chk("bp_d2_taken", rd_credit_cnt, 0);
    chk("bp_d1_rid", bus.rid, 4'h2);
    chk("bp_d1_rresp", bus.rresp, 2'd2);
    bus.rready = 1'b1;
    tick();
    chk("bp_d2_rdata", bus.rdata, D2);
    chk("bp_d2_rid", bus.rid, 4'h3);
    chk("bp_d2_rresp", bus.rresp, 2'd1);
    tick();
    bus.rready = 1'b0;
    #1;
    chk("bp_empty", bus.rvalid, 0);
    chk("bp_no_unexp", rd_unexp_last, 0);

    // unexpected rlast with no reads outstanding
    bus.pad_biu_rvalid = 1'b1;
    r_drive(DA, 8'h07, 1'b1, 2'd0);
    tick();
    bus.pad_biu_rvalid = 1'b0;
    #1;
    chk("unexp_credit", rd_credit_cnt, 0);
    chk("unexp_flag", rd_unexp_last, 1);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    tick();
    tick();
    chk("unexp_sticky", rd_unexp_last, 1);
    chk("unexp_clk_en_idle", read_channel_clk_en, 0);

    // full-rate R streaming with the consumer always ready
    bus.rready = 1'b1;
    bus.pad_biu_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_drive(E0 + 128'(i), 8'h00, 1'b0, 2'd0);
      tick();
      chk("stream_rdata", bus.rdata, E0 + 128'(i));
      chk("stream_rready", bus.biu_pad_rready, 1);
    end
    bus.pad_biu_rvalid = 1'b0;
    tick();
    bus.rready = 1'b0;
    #1;
    chk("stream_drained", bus.rvalid, 0);

    // reset with AR and R entries queued
    bus.arvalid = 1'b1;
    ar_drive(ADDR_A, 4'h9, 2'd2);
    bus.pad_biu_rvalid = 1'b1;
    r_drive(D1, 8'h05, 1'b0, 2'd0);
    tick();
    tick();
    bus.arvalid = 1'b0;
    bus.pad_biu_rvalid = 1'b0;
    #1;
    chk("mid_credit", rd_credit_cnt, 2);
    chk("mid_arvalid", bus.biu_pad_arvalid, 1);
    chk("mid_rvalid", bus.rvalid, 1);
    chk("mid_clk_en", read_channel_clk_en, 1);
    cpurst = 1'b1;
    tick();
    chk("mrst_arvalid", bus.biu_pad_arvalid, 0);
    chk("mrst_rvalid", bus.rvalid, 0);
    chk("mrst_credit", rd_credit_cnt, 0);
    chk("mrst_unexp", rd_unexp_last, 0);
    chk("mrst_arready", bus.arready, 0);
    chk("mrst_rdata", bus.rdata, 0);
    chk("mrst_araddr", bus.biu_pad_araddr, 0);
    cpurst = 1'b0;
    bus.rready = 1'b1;
    bus.pad_biu_arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rvalid", bus.rvalid, 0);
      chk("post_arvalid", bus.biu_pad_arvalid, 0);
    end
    chk("post_arready", bus.arready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aq_biu_rd_chnl_fifo.md
# aq_biu_rd_chnl_fifo

Parametrised AXI read-channel buffer between the core-side read requesters and the BIU pad interface. It holds a multi-entry AR FIFO and a multi-entry R FIFO. Real R-channel backpressure is applied toward the pad, and a credit counter caps outstanding reads. It supports configurable address, data, ID and length widths, and pad-side handshakes are qualified by the bus clock-ratio enable `axim_clk_en`.

## Interface
Parameters:
- PADDR, 40, address width
- DATAW, 128, R data width
- IDW, 4, core-side ID width (≤8)
- LENW, 2, core-side burst-length width (≤8)
- ARDEPTH, 2, AR FIFO entries (power of 2, ≥1)
- RDEPTH, 2, R FIFO entries (power of 2, ≥1)
- MAXOUT, 4, maximum reads accepted upstream and not yet completed by rlast (≥1)

Ports:
- biu_clk  in  1  single clock for the whole block
- cpurst  in  1  reset, synchronous, active-high
- axim_clk_en  in  1  pad-side handshake qualifier
- arvalid/arready  in/out  1  core AR handshake
- araddr  in  PADDR; arid  in  IDW; arlen  in  LENW; arsize  in  3; arburst  in  2; arcache  in  4; arprot  in  3; arlock  in  1 — AR payload
- biu_pad_arvalid  out  1; pad_biu_arready  in  1
- biu_pad_araddr  out  PADDR; biu_pad_arid  out  8; biu_pad_arlen  out  8; biu_pad_arsize  out  3; biu_pad_arburst  out  2; biu_pad_arcache  out  4; biu_pad_arprot  out  3; biu_pad_arlock  out  1
- pad_biu_rvalid  in  1; biu_pad_rready  out  1; pad_biu_rdata  in  DATAW; pad_biu_rid  in  8; pad_biu_rlast  in  1; pad_biu_rresp  in  2
- rvalid  out  1; rready  in  1; rdata  out  DATAW; rid  out  IDW; rlast  out  1; rresp  out  2 — core R handshake
- rd_credit_cnt  out  clog2(MAXOUT+1)  reads in flight
- rd_unexp_last  out  1  sticky error flag
- read_channel_clk_en  out  1  activity indication for clock gating

## Operation
AR FIFO:
- Core push on arvalid & arready.
- arready = !cpurst & (ar_cnt != ARDEPTH) & (crd < MAXOUT).
- ID and length are zero-extended to 8 bits.
- biu_pad_arvalid = (ar_cnt != 0). The head payload drives biu_pad_ar*.
- Pad pop on biu_pad_arvalid & pad_biu_arready & axim_clk_en.
- The head stays stable until popped, including while axim_clk_en is low.

Credit counter crd:
- Increments on core AR push.
- Decrements on a pad R beat with pad_biu_rlast.
- Simultaneous increment and decrement leave it unchanged.
- A decrement at crd==0 holds 0 and sets rd_unexp_last, which stays set until reset.
- rd_credit_cnt = crd.

R FIFO:
- biu_pad_rready = !cpurst & (r_cnt != RDEPTH), computed from registered state only.
- Pad push on pad_biu_rvalid & biu_pad_rready & axim_clk_en. rid takes pad_biu_rid[IDW-1:0].
- rvalid = (r_cnt != 0); the head drives rdata/rid/rlast/rresp.
- Core pop on rvalid & rready, independent of axim_clk_en.
- When full, a same-cycle pop does not admit a push, because rready is not combinationally dependent on pop.
- Simultaneous push and pop when not full: count is unchanged and ordering is preserved.

Pointers wrap modulo depth. Counts range from 0 to DEPTH inclusive.

read_channel_clk_en = any AR push/pop, any R push/pop, or either FIFO non-empty.

## Timing
- Reset (cpurst high at a biu_clk edge): all FIFO counts, pointers, crd and rd_unexp_last clear.
- While cpurst is high, all handshakes are ignored and arready = biu_pad_rready = 0.
- After reset: biu_pad_arvalid = rvalid = 0, and all payload outputs are 0. Storage is cleared so the head reads 0.
- Reset mid-burst discards all entries and credits without emitting further beats.
- AR latency: a core push at edge N gives biu_pad_arvalid high after edge N (1 cycle).
- R latency: a pad beat accepted at edge N gives rvalid high after edge N (1 cycle).
- Full-rate throughput:
  - AR with ARDEPTH ≥ 2 and R with RDEPTH ≥ 2, when axim_clk_en and the consumer are always ready.
  - A depth-1 FIFO gives one transfer per 2 cycles.

## Test plan
- Reset: hold cpurst 2 cycles → arready=0, biu_pad_rready=0, biu_pad_arvalid=0, rvalid=0, rd_credit_cnt=0. Release → arready=1, biu_pad_rready=1.
- AR stall: push araddr=0x12_3456_7880, arid=0x5, arlen=3 with pad_biu_arready=0 → biu_pad_arid=0x05, biu_pad_arlen=0x03 next cycle. Push again → ar_cnt=2 and arready=0. Raise pad_biu_arready with axim_clk_en toggling 1/0 → pops only on enabled cycles, in order.
- Credit cap (MAXOUT=4): issue 4 ARs with no R → arready=0 and rd_credit_cnt=4. Inject one rlast beat → rd_credit_cnt=3 and arready=1 next cycle. Same-cycle AR push + rlast → count stays 3.
- R backpressure (RDEPTH=2): rready=0, push beats D0, D1 → biu_pad_rready=0. Pop and offer D2 in the same cycle → D2 not accepted that cycle, accepted the next. Core receives D0, D1, D2 in order.
- Unexpected rlast: with crd=0, pad delivers an rlast beat → rd_credit_cnt stays 0, rd_unexp_last=1 and stays set until cpurst.
- Mid-operation reset: with 2 AR and 2 R entries queued, assert cpurst for 1 cycle → all valids 0 next cycle, and no stale beat appears after release.
